bconv1_pe: RTL and testbench
============================

BCONV1_PE -- requirements
Module: bconv1_pe

Interface
REQ-001 Parameter NCH, default 8: number of output channels.
REQ-002 Parameter WIN, default 7: window width in bits; fixed to the upstream slide width.
REQ-003 Port clk, input, 1: single clock; all state on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port slide_data, input, WIN: binary ECG window from the sliding-window unit, one per clock.
REQ-006 Port ecg_data_val, input, 1: rises once and stays high while slide_data is valid.
REQ-007 Port trans_done, input, 1: one-cycle pulse; the slide_data sampled in this cycle is the last valid window of the frame.
REQ-008 Port cfg_we, input, 1: configuration write strobe.
REQ-009 Port cfg_addr, input, 3: channel index for the write.
REQ-010 Port cfg_wdata, input, 11: [10:4] weight pattern (WIN bits), [3:0] threshold.
REQ-011 Port restart, input, 1: synchronous return from DONE to IDLE.
REQ-012 Port act_out, output, NCH: binary activation vector, bit c = channel c.
REQ-013 Port act_val, output, 1: act_out valid this cycle.
REQ-014 Port win_cnt, output, 9: number of windows accepted in the current frame (saturates at 511).
REQ-015 Port frame_done, output, 1: one-cycle pulse after the last activation leaves.
REQ-016 Port busy, output, 1: high in RUN and FLUSH.

Function
REQ-017 FSM states: IDLE, RUN, FLUSH, DONE.
REQ-018 IDLE->RUN when ecg_data_val=1; the window sampled in that same cycle is accepted.
REQ-019 RUN: accept one window per cycle; RUN->FLUSH in the cycle trans_done=1 (that window is accepted).
REQ-020 FLUSH: accept nothing; lasts exactly 2 cycles, then ->DONE.
REQ-021 DONE: frame_done=1 for the first DONE cycle only; remain in DONE, ignoring ecg_data_val, until restart=1, then ->IDLE.
REQ-022 Stage 1 (registered): per channel, pop[c] = popcount(~(slide_data ^ weight[c])), 3 bits, range 0..7.
REQ-023 Stage 2 (registered): act_out[c] = (pop[c] >= thr[c]); thr compared unsigned at 4 bits; thr=0 yields always 1, thr>=8 yields always 0.
REQ-024 Latency: window accepted at cycle t gives act_val=1 with act_out at cycle t+2; one result per accepted window, in order, no gaps.
REQ-025 act_val=0 for any cycle without a corresponding accepted window; act_out holds its last value when act_val=0.
REQ-026 win_cnt increments per accepted window, clears on IDLE->RUN, holds through FLUSH and DONE.
REQ-027 frame_done coincides with the cycle after the final act_val pulse.
REQ-028 Config writes: take effect only in IDLE or DONE; ignored in RUN and FLUSH.
REQ-029 A config write and an accept in the same IDLE cycle: the window uses the pre-write weights.
REQ-030 trans_done while in IDLE: the window is accepted, the FSM goes directly to FLUSH, and win_cnt=1.
REQ-031 restart outside DONE: ignored.

Reset
REQ-032 rst_n low: FSM=IDLE; act_out=0, act_val=0, win_cnt=0, frame_done=0, busy=0; pipeline valid bits cleared; all weights=0 and all thresholds=4.
REQ-033 Reset mid-frame: all in-flight results are discarded, with no frame_done pulse.

Structure
REQ-034 A shared package holds: NCH, WIN, the FSM state encoding, the cfg_wdata field offsets, and the reset threshold constant.
REQ-035 One sub-module, bconv_xnor_pop, implements the WIN-bit XNOR-popcount; it is instantiated NCH times.

Verification
REQ-036 Reset, load weight[0]=7'h7F with thr=4, stream 7'h0F -> act_out[0]=1 two cycles after accept (pop=4).
REQ-037 Same weight and stream 7'h07 -> act_out[0]=0 (pop=3); thr=0 -> always 1; thr=8 -> always 0.
REQ-038 Full frame of 200 windows ending with trans_done -> exactly 200 act_val pulses, win_cnt=200, frame_done 3 cycles after the trans_done cycle.
REQ-039 cfg_we during RUN changing weight[2] -> no effect on outputs; the same write issued in DONE takes effect after restart.
REQ-040 rst_n asserted at window 50 -> outputs zero immediately, no frame_done, weights restored to reset values.
REQ-041 trans_done on the very first valid cycle -> one act_val pulse, win_cnt=1, frame_done follows.

Source files
------------

// File: rtl/bconv1_pkg.sv
// Shared constants for the binary conv-1 processing element: geometry,
// FSM state encoding and configuration word layout.
package bconv1_pkg;

  localparam int DEF_NCH = 8;
  localparam int DEF_WIN = 7;

  localparam int CFG_W       = 11;
  localparam int CFG_THR_LSB = 0;
  localparam int CFG_WGT_LSB = 4;
  localparam int THR_W       = 4;

  localparam logic [THR_W-1:0] THR_RST = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bconv_xnor_pop.sv
// Binary dot product of one window against one weight pattern:
// count of bit positions where the two agree.
module bconv_xnor_pop
  import bconv1_pkg::*;
#(
  parameter int WIN   = DEF_WIN,
  parameter int POP_W = $clog2(WIN + 1)
) (
  input  logic [WIN-1:0]   win_i,
  input  logic [WIN-1:0]   wgt_i,
  output logic [POP_W-1:0] pop_o
);

  logic [WIN-1:0] match;

  always_comb begin
    match = ~(win_i ^ wgt_i);
    pop_o = '0;
    for (int i = 0; i < WIN; i++) begin
      pop_o = pop_o + POP_W'(match[i]);
    end
  end

endmodule

// File: rtl/bconv1_pe.sv
// Binary 1-D convolution PE: NCH XNOR-popcount channels with per-channel
// thresholds, two-stage pipeline, frame-level FSM (IDLE/RUN/FLUSH/DONE).
module bconv1_pe
  import bconv1_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int WIN = DEF_WIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIN-1:0]   slide_data,
  input  logic             ecg_data_val,
  input  logic             trans_done,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CFG_W-1:0] cfg_wdata,
  input  logic             restart,
  output logic [NCH-1:0]   act_out,
  output logic             act_val,
  output logic [8:0]       win_cnt,
  output logic             frame_done,
  output logic             busy
);

  localparam int POP_W = $clog2(WIN + 1);

  state_e            state_q;
  logic              flush_q;
  logic [8:0]        win_cnt_q;
  logic              frame_done_q;
  logic              accept_d;
  logic              cfg_en_d;

  logic [WIN-1:0]    wgt_q    [NCH];
  logic [THR_W-1:0]  thr_q    [NCH];
  logic [POP_W-1:0]  pop_d    [NCH];
  logic [POP_W-1:0]  pop_p1_q [NCH];
  logic [THR_W-1:0]  thr_p1_q [NCH];
  logic              vld_p1_q;
  logic [NCH-1:0]    act_d;
  logic [NCH-1:0]    act_p2_q;
  logic              vld_p2_q;

  function automatic logic thr_hit(input logic [POP_W-1:0] pop,
                                   input logic [THR_W-1:0] thr);
    return 32'(pop) >= 32'(thr);
  endfunction

  assign accept_d = (state_q == ST_RUN) || (state_q == ST_IDLE && ecg_data_val);
  assign cfg_en_d = cfg_we && (state_q == ST_IDLE || state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      flush_q      <= 1'b0;
      win_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ecg_data_val) begin
            win_cnt_q <= 9'd1;
            flush_q   <= 1'b0;
            state_q   <= trans_done ? ST_FLUSH : ST_RUN;
          end
        end
        ST_RUN: begin
          if (win_cnt_q != 9'h1FF) win_cnt_q <= win_cnt_q + 9'd1;
          if (trans_done) begin
            flush_q <= 1'b0;
            state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Two flush cycles drain both pipeline stages before DONE.
          if (flush_q) begin
            state_q      <= ST_DONE;
            frame_done_q <= 1'b1;
          end else begin
            flush_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (restart) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        wgt_q[c] <= '0;
        thr_q[c] <= THR_RST;
      end
    end else if (cfg_en_d) begin
      for (int c = 0; c < NCH; c++) begin
        if (32'(cfg_addr) == c) begin
          wgt_q[c] <= cfg_wdata[CFG_WGT_LSB +: WIN];
          thr_q[c] <= cfg_wdata[CFG_THR_LSB +: THR_W];
        end
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    bconv_xnor_pop #(.WIN(WIN), .POP_W(POP_W)) u_pop (
      .win_i (slide_data),
      .wgt_i (wgt_q[c]),
      .pop_o (pop_d[c])
    );
  end

  // Stage 1: popcount plus the threshold in force when the window was accepted.
  always_ff @(posedge clk) begin
    if (accept_d) begin
      pop_p1_q <= pop_d;
      thr_p1_q <= thr_q;
    end
  end

  always_comb begin
    act_d = '0;
    for (int c = 0; c < NCH; c++) begin
      act_d[c] = thr_hit(pop_p1_q[c], thr_p1_q[c]);
    end
  end

  // Stage 2: thresholded activation; holds its value between valid results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      act_p2_q <= '0;
    end else begin
      vld_p1_q <= accept_d;
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) act_p2_q <= act_d;
    end
  end

  assign act_out    = act_p2_q;
  assign act_val    = vld_p2_q;
  assign win_cnt    = win_cnt_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_bconv1_pe.sv
// Directed bench for bconv1_pe: thresholds, latency, long frame,
// config gating, mid-frame reset and single-window frames.
module tb_bconv1_pe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  slide_data;
  logic        ecg_data_val;
  logic        trans_done;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [10:0] cfg_wdata;
  logic        restart;
  logic [7:0]  act_out;
  logic        act_val;
  logic [8:0]  win_cnt;
  logic        frame_done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int pulses;
  int n;

  always #5 clk = ~clk;

  bconv1_pe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .slide_data   (slide_data),
    .ecg_data_val (ecg_data_val),
    .trans_done   (trans_done),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .restart      (restart),
    .act_out      (act_out),
    .act_val      (act_val),
    .win_cnt      (win_cnt),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] a, input logic [6:0] w, input logic [3:0] t);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = {w, t};
    tick;
    cfg_we    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; slide_data = '0; ecg_data_val = 1'b0; trans_done = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; restart = 1'b0;
    #3;
    check("rst_act_out", 32'(act_out), 32'h0);
    check("rst_act_val", 32'(act_val), 32'h0);
    check("rst_win_cnt", 32'(win_cnt), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    tick; tick;
    rst_n = 1'b1;

    // Frame 1: ch0 weight 7F thr 4, others weight 0 thr 4.
    cfg(3'd0, 7'h7F, 4'd4);
    check("idle_busy", 32'(busy), 32'h0);
    ecg_data_val = 1'b1; slide_data = 7'h0F;
    tick;
    check("f1_busy_run", 32'(busy), 32'h1);
    check("f1_cnt1", 32'(win_cnt), 32'd1);
    check("f1_val_lat1", 32'(act_val), 32'h0);
    slide_data = 7'h07; restart = 1'b1;
    tick;
    restart = 1'b0;
    check("f1_val_w0", 32'(act_val), 32'h1);
    check("f1_act_w0_pop4", 32'(act_out), 32'h01);
    check("f1_cnt2", 32'(win_cnt), 32'd2);
    check("f1_restart_ignored", 32'(busy), 32'h1);
    slide_data = 7'h0F; trans_done = 1'b1;
    tick;
    trans_done = 1'b0;
    check("f1_act_w1_pop3", 32'(act_out), 32'hFE);
    check("f1_cnt3", 32'(win_cnt), 32'd3);
    tick;
    check("f1_val_w2", 32'(act_val), 32'h1);
    check("f1_act_w2", 32'(act_out), 32'h01);
    check("f1_busy_flush", 32'(busy), 32'h1);
    check("f1_fd_early", 32'(frame_done), 32'h0);
    tick;
    check("f1_fd", 32'(frame_done), 32'h1);
    check("f1_val_done", 32'(act_val), 32'h0);
    check("f1_act_hold", 32'(act_out), 32'h01);
    check("f1_busy_done", 32'(busy), 32'h0);
    check("f1_cnt_hold", 32'(win_cnt), 32'd3);
    tick;
    check("f1_fd_pulse", 32'(frame_done), 32'h0);
    check("f1_done_ignores_val", 32'(busy), 32'h0);
    ecg_data_val = 1'b0;

    // In DONE: ch0 thr 0 (always 1), ch1 thr 8 (always 0).
    cfg(3'd0, 7'h7F, 4'd0);
    cfg(3'd1, 7'h00, 4'd8);
    restart = 1'b1; tick; restart = 1'b0;

    // Frame 2: trans_done on the first valid cycle.
    ecg_data_val = 1'b1; slide_data = 7'h00; trans_done = 1'b1;
    tick;
    trans_done = 1'b0; ecg_data_val = 1'b0;
    check("f2_cnt1", 32'(win_cnt), 32'd1);
    check("f2_busy_flush", 32'(busy), 32'h1);
    check("f2_val_lat1", 32'(act_val), 32'h0);
    tick;
    check("f2_val", 32'(act_val), 32'h1);
    check("f2_act_thr0_thr8", 32'(act_out), 32'hFD);
    tick;
    check("f2_fd", 32'(frame_done), 32'h1);
    check("f2_val_done", 32'(act_val), 32'h0);
    restart = 1'b1; tick; restart = 1'b0;

    // Frame 3: 200 windows, a ch2 write during RUN must be ignored.
    pulses = 0;
    ecg_data_val = 1'b1;
    for (int i = 0; i < 200; i++) begin
      slide_data = 7'h00;
      trans_done = (i == 199);
      cfg_we     = (i == 10);
      cfg_addr   = 3'd2;
      cfg_wdata  = {7'h7F, 4'd4};
      tick;
      if (act_val) begin
        pulses++;
        check("f3_act", 32'(act_out), 32'hFD);
      end
    end
    trans_done = 1'b0; cfg_we = 1'b0; ecg_data_val = 1'b0;
    n = 0;
    while (frame_done !== 1'b1 && n < 10) begin
      tick;
      n++;
      if (act_val) begin
        pulses++;
        check("f3_act_tail", 32'(act_out), 32'hFD);
      end
    end
    check("f3_fd_seen", 32'(frame_done), 32'h1);
    check("f3_fd_latency", 32'(n), 32'd2);
    check("f3_pulses", 32'(pulses), 32'd200);
    check("f3_win_cnt", 32'(win_cnt), 32'd200);

    // Same ch2 write in DONE takes effect next frame.
    cfg(3'd2, 7'h7F, 4'd4);
    restart = 1'b1; tick; restart = 1'b0;

    // Frame 4: ch3 write in the accept cycle must not affect this window.
    ecg_data_val = 1'b1; slide_data = 7'h00; trans_done = 1'b1;
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = {7'h7F, 4'd4};
    tick;
    cfg_we = 1'b0; trans_done = 1'b0; ecg_data_val = 1'b0;
    tick;
    check("f4_val", 32'(act_val), 32'h1);
    check("f4_act_prewrite", 32'(act_out), 32'hF9);
    tick;
    check("f4_fd", 32'(frame_done), 32'h1);
    restart = 1'b1; tick; restart = 1'b0;

    // Frame 5: reset asserted after 50 windows.
    ecg_data_val = 1'b1; slide_data = 7'h00;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (i == 3) begin
        check("f5_val", 32'(act_val), 32'h1);
        check("f5_act_ch3_written", 32'(act_out), 32'hF1);
      end
    end
    check("f5_cnt50", 32'(win_cnt), 32'd50);
    #2 rst_n = 1'b0;
    #1;
    check("f5_rst_act_out", 32'(act_out), 32'h0);
    check("f5_rst_act_val", 32'(act_val), 32'h0);
    check("f5_rst_win_cnt", 32'(win_cnt), 32'h0);
    check("f5_rst_busy", 32'(busy), 32'h0);
    ecg_data_val = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("f5_no_fd", 32'(frame_done), 32'h0);
      check("f5_no_val", 32'(act_val), 32'h0);
    end

    // Frame 6: weights back to 0, thresholds back to 4.
    ecg_data_val = 1'b1; slide_data = 7'h00; trans_done = 1'b1;
    tick;
    trans_done = 1'b0; ecg_data_val = 1'b0;
    check("f6_cnt1", 32'(win_cnt), 32'd1);
    tick;
    check("f6_val", 32'(act_val), 32'h1);
    check("f6_act_reset_cfg", 32'(act_out), 32'hFF);
    tick;
    check("f6_fd", 32'(frame_done), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
